uart_rx_tx_buffer: RTL and testbench
====================================

Name: uart_rx_tx_buffer

Overview:
- Byte FIFO between uart_receiver and uart_transmitter in the echo path.
- Captures each byte the receiver completes and holds it in a circular buffer.
- Drains the buffer into the transmitter using the transmitter's run/done handshake.
- Replaces the single-byte direct hand-off, so back-to-back received bytes are no longer lost while TX is busy.

Parameters:
DEPTH, 16, number of byte entries; power of two, minimum 2
ADDR_W, 4, pointer width, equals log2(DEPTH)

Ports:
CLKIN  input  1  system clock; all logic on posedge
RESET  input  1  synchronous, active-high reset
rx_data  input  8  byte from uart_receiver; valid on the rx_done rising edge
rx_done  input  1  receiver done level; a 0->1 transition means one new byte
rx_run  output  1  receiver enable; high whenever the FIFO is not full
tx_data  output  8  registered byte presented to uart_transmitter
tx_run  output  1  transmit request to uart_transmitter
tx_done  input  1  transmitter done level; a 0->1 transition means the byte was sent
empty  output  1  FIFO holds 0 entries
full  output  1  FIFO holds DEPTH entries
overflow  output  1  sticky flag: a byte was dropped because the FIFO was full

Behaviour:
- Reset values (the cycle after RESET is sampled high): rx_run=1, tx_run=0, tx_data=8'h00, empty=1, full=0, overflow=0.
- Reset also clears: read and write pointers, count, edge-detect registers (to 0), TX FSM (to IDLE).
- RESET mid-transfer aborts it: tx_run drops the next cycle and all stored bytes are discarded.
- Edge detection: rx_done and tx_done are each registered once; an event is (current & ~previous). A level held high produces exactly one event.
- Push:
  - Happens on an rx event.
  - Writes rx_data at wr_ptr, increments wr_ptr modulo DEPTH (natural wrap at ADDR_W bits), count+1.
  - Visible to the TX side on the following cycle.
- Pop: increments rd_ptr modulo DEPTH, count-1.
- Count is ADDR_W+1 bits wide. empty = (count==0); full = (count==DEPTH). Both are registered and update the cycle after a push or pop.
- Simultaneous push and pop: both take effect and count is unchanged.
  - When full, a push in the same cycle as a pop is accepted and overflow is not set.
  - When empty, a same-cycle push cannot be popped, since the TX FSM only loads from a non-empty FIFO.
- Overflow: a push while full with no same-cycle pop drops the byte, sets overflow=1 until RESET, and leaves pointers unchanged.
- rx_run = ~full, registered.
- TX FSM states:
  - IDLE: if !empty, then tx_data <= mem[rd_ptr] and go to REQ. Otherwise stay.
  - REQ: tx_run <= 1; go to BUSY.
  - BUSY: hold tx_run=1 and tx_data stable. On a tx_done event: tx_run <= 0, pop, go to GAP.
  - GAP: wait until registered tx_done==0, then go to IDLE. This blocks a stale done from acknowledging the next byte.
- Latency, with the transmitter done level low at the time of the push:
  - First byte into an empty FIFO: tx_run rises 4 CLKIN cycles after the rx_done rising edge (edge register, push, IDLE load, REQ).
  - Between bytes: at least 2 cycles of tx_run low between consecutive requests.
- Ordering is strict FIFO. Every accepted byte is sent exactly once.

Optional Feature:
- Macro: UART_BUF_LEVEL_EN.
- When defined:
  - Adds output level [ADDR_W:0], equal to the registered count.
  - Adds output half, equal to (count >= DEPTH/2); the top level drives a status LED from it.
- When undefined: neither port exists and the core behaviour is identical.

Test Plan:
- Reset, then a single rx_done pulse with rx_data=8'hA5 -> tx_run rises 4 cycles later with tx_data=8'hA5. tx_done pulse -> tx_run falls, empty=1.
- Three bytes 8'h01, 8'h02, 8'h03 pushed while tx_done is held low -> transmitted in order 01, 02, 03. Each tx_run deasserts after its done, and the next request waits for done to return low.
- DEPTH+1 pushes with no tx_done: full=1 and rx_run=0 after 16 bytes. The 17th byte (8'hFF) is dropped and overflow=1. Draining yields exactly the first 16 bytes.
- FIFO full, push 8'h5A in the same cycle as a tx_done event -> byte accepted, overflow stays 0, count stays 16, and 8'h5A is the last byte out.
- rx_done held high for 10 cycles -> exactly one byte stored. RESET asserted while tx_run=1 -> tx_run=0 and empty=1 the next cycle, and no further transmissions occur.
- With UART_BUF_LEVEL_EN defined, 8 pushes -> level=8, half=1. After one pop -> level=7, half=0.

Source files
------------

// File: rtl/uart_rx_tx_buffer.sv
// rtl/uart_rx_tx_buffer.sv - byte FIFO between uart_receiver and uart_transmitter
// Define UART_BUF_LEVEL_EN to add the level/half status outputs.
module uart_rx_tx_buffer #(
  parameter int DEPTH  = 16,
  parameter int ADDR_W = 4
) (
  input  logic              CLKIN,
  input  logic              RESET,
  input  logic [7:0]        rx_data,
  input  logic              rx_done,
  output logic              rx_run,
  output logic [7:0]        tx_data,
  output logic              tx_run,
  input  logic              tx_done,
  output logic              empty,
  output logic              full,
  output logic              overflow
`ifdef UART_BUF_LEVEL_EN
  ,
  output logic [ADDR_W:0]   level,
  output logic              half
`endif
);

  localparam logic [ADDR_W:0] FULL_CNT = (ADDR_W+1)'(DEPTH);

  typedef enum logic [1:0] {IDLE, REQ, BUSY, GAP} state_t;

  state_t            state, state_next;
  logic [7:0]        mem [DEPTH];
  logic [ADDR_W-1:0] wr_ptr, rd_ptr;
  logic [ADDR_W:0]   count, count_next;
  logic              rx_d1, rx_d2, tx_d1, tx_d2;
  logic              rx_ev, tx_ev;
  logic              push_ok, pop;
  logic              tx_run_next;
  logic [7:0]        tx_data_next;

  assign rx_ev   = rx_d1 & ~rx_d2;
  assign tx_ev   = tx_d1 & ~tx_d2;
  // A same-cycle pop frees the slot, so a push while full is still accepted.
  assign push_ok = rx_ev & (~full | pop);

  always_comb begin
    count_next = count;
    if (push_ok && !pop)
      count_next = count + 1'b1;
    else if (!push_ok && pop)
      count_next = count - 1'b1;
  end

  always_comb begin
    state_next   = state;
    tx_run_next  = tx_run;
    tx_data_next = tx_data;
    pop          = 1'b0;
    case (state)
      IDLE: begin
        if (!empty) begin
          tx_data_next = mem[rd_ptr];
          state_next   = REQ;
        end
      end
      REQ: begin
        tx_run_next = 1'b1;
        state_next  = BUSY;
      end
      BUSY: begin
        if (tx_ev) begin
          tx_run_next = 1'b0;
          pop         = 1'b1;
          state_next  = GAP;
        end
      end
      // A done level still high from the previous byte must not ack the next.
      GAP: begin
        if (!tx_d1)
          state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge CLKIN) begin
    if (push_ok)
      mem[wr_ptr] <= rx_data;
  end

  always_ff @(posedge CLKIN) begin
    if (RESET) begin
      state    <= IDLE;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      rx_d1    <= 1'b0;
      rx_d2    <= 1'b0;
      tx_d1    <= 1'b0;
      tx_d2    <= 1'b0;
      tx_run   <= 1'b0;
      tx_data  <= 8'h00;
      empty    <= 1'b1;
      full     <= 1'b0;
      rx_run   <= 1'b1;
      overflow <= 1'b0;
    end else begin
      state   <= state_next;
      rx_d1   <= rx_done;
      rx_d2   <= rx_d1;
      tx_d1   <= tx_done;
      tx_d2   <= tx_d1;
      tx_run  <= tx_run_next;
      tx_data <= tx_data_next;
      if (push_ok)
        wr_ptr <= wr_ptr + 1'b1;
      if (pop)
        rd_ptr <= rd_ptr + 1'b1;
      count  <= count_next;
      empty  <= (count_next == '0);
      full   <= (count_next == FULL_CNT);
      rx_run <= (count_next != FULL_CNT);
      if (rx_ev && full && !pop)
        overflow <= 1'b1;
    end
  end

`ifdef UART_BUF_LEVEL_EN
  assign level = count;
  assign half  = (count >= (ADDR_W+1)'(DEPTH / 2));
`endif

endmodule

// File: tb/tb_uart_rx_tx_buffer.sv
// tb/tb_uart_rx_tx_buffer.sv - directed self-checking bench for uart_rx_tx_buffer
module tb_uart_rx_tx_buffer;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] rx_data;
  logic       rx_done;
  logic       rx_run;
  logic [7:0] tx_data;
  logic       tx_run;
  logic       tx_done;
  logic       empty;
  logic       full;
  logic       overflow;
`ifdef UART_BUF_LEVEL_EN
  logic [4:0] level;
  logic       half;
`endif

  int errors = 0;
  int checks = 0;

  uart_rx_tx_buffer #(.DEPTH(16), .ADDR_W(4)) dut (
    .CLKIN    (clk),
    .RESET    (reset),
    .rx_data  (rx_data),
    .rx_done  (rx_done),
    .rx_run   (rx_run),
    .tx_data  (tx_data),
    .tx_run   (tx_run),
    .tx_done  (tx_done),
    .empty    (empty),
    .full     (full),
    .overflow (overflow)
`ifdef UART_BUF_LEVEL_EN
    ,
    .level    (level),
    .half     (half)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_reset();
    reset   = 1'b1;
    rx_done = 1'b0;
    tx_done = 1'b0;
    rx_data = 8'h00;
    cyc(1);
    reset = 1'b0;
    cyc(1);
  endtask

  task automatic push(input logic [7:0] b);
    rx_data = b;
    rx_done = 1'b1;
    cyc(1);
    rx_done = 1'b0;
    cyc(1);
  endtask

  task automatic wait_req(output int n);
    n = 0;
    while (!tx_run && n < 200) begin
      cyc(1);
      n++;
    end
  endtask

  task automatic send_one(input string tag, input logic [7:0] exp);
    int n;
    wait_req(n);
    check({tag, "_req"}, 32'(tx_run), 1);
    check({tag, "_data"}, 32'(tx_data), 32'(exp));
    tx_done = 1'b1;
    n = 0;
    while (tx_run && n < 20) begin
      cyc(1);
      n++;
    end
    check({tag, "_drop"}, 32'(tx_run), 0);
    tx_done = 1'b0;
    cyc(1);
  endtask

  task automatic watch_idle(input string tag, input int n);
    logic seen;
    seen = 1'b0;
    for (int i = 0; i < n; i++) begin
      cyc(1);
      if (tx_run) seen = 1'b1;
    end
    check(tag, 32'(seen), 0);
  endtask

  initial begin
    int n;
    logic seen;

    // reset values
    do_reset();
    check("rst_rx_run", 32'(rx_run), 1);
    check("rst_tx_run", 32'(tx_run), 0);
    check("rst_tx_data", 32'(tx_data), 0);
    check("rst_empty", 32'(empty), 1);
    check("rst_full", 32'(full), 0);
    check("rst_overflow", 32'(overflow), 0);

    // single byte: tx_run rises on the 4th edge after rx_done rises
    rx_data = 8'hA5;
    rx_done = 1'b1;
    cyc(1);
    rx_done = 1'b0;
    cyc(2);
    check("lat_empty", 32'(empty), 0);
    check("lat_early", 32'(tx_run), 0);
    cyc(1);
    check("lat_req", 32'(tx_run), 1);
    check("lat_data", 32'(tx_data), 32'h A5);
    tx_done = 1'b1;
    cyc(1);
    check("done_hold", 32'(tx_run), 1);
    cyc(1);
    check("done_drop", 32'(tx_run), 0);
    check("done_empty", 32'(empty), 1);
    tx_done = 1'b0;
    cyc(3);

    // three bytes in order; stale done blocks the next request
    push(8'h01);
    push(8'h02);
    push(8'h03);
    for (int i = 0; i < 3; i++) begin
      wait_req(n);
      if (i > 0) check($sformatf("gap_cycles_%0d", i), n, 4);
      check($sformatf("seq_req_%0d", i), 32'(tx_run), 1);
      check($sformatf("seq_data_%0d", i), 32'(tx_data), i + 1);
      tx_done = 1'b1;
      cyc(2);
      check($sformatf("seq_drop_%0d", i), 32'(tx_run), 0);
      seen = 1'b0;
      for (int k = 0; k < 3; k++) begin
        cyc(1);
        if (tx_run) seen = 1'b1;
      end
      check($sformatf("seq_stale_%0d", i), 32'(seen), 0);
      tx_done = 1'b0;
    end
    cyc(2);
    check("seq_empty", 32'(empty), 1);

    // fill to 16, 17th dropped, drain exactly 16
    do_reset();
    for (int i = 0; i < 16; i++) push(8'(8'h10 + i));
    cyc(2);
    check("fill_full", 32'(full), 1);
    check("fill_rx_run", 32'(rx_run), 0);
    check("fill_ovf", 32'(overflow), 0);
    push(8'hFF);
    cyc(2);
    check("ovf_set", 32'(overflow), 1);
    check("ovf_full", 32'(full), 1);
    for (int i = 0; i < 16; i++) send_one($sformatf("drain_%0d", i), 8'(8'h10 + i));
    watch_idle("drain_no_extra", 20);
    check("drain_empty", 32'(empty), 1);
    check("ovf_sticky", 32'(overflow), 1);

    // full FIFO, push in the same cycle as the done event
    do_reset();
    for (int i = 0; i < 16; i++) push(8'(8'h20 + i));
    cyc(2);
    check("sim_full_pre", 32'(full), 1);
    check("sim_busy", 32'(tx_run), 1);
    check("sim_head", 32'(tx_data), 32'h20);
    rx_data = 8'h5A;
    rx_done = 1'b1;
    tx_done = 1'b1;
    cyc(1);
    rx_done = 1'b0;
    cyc(1);
    check("sim_drop", 32'(tx_run), 0);
    tx_done = 1'b0;
    cyc(1);
    check("sim_ovf", 32'(overflow), 0);
    check("sim_full_post", 32'(full), 1);
    for (int i = 1; i < 16; i++) send_one($sformatf("sim_out_%0d", i), 8'(8'h20 + i));
    send_one("sim_last", 8'h5A);
    watch_idle("sim_no_extra", 20);
    check("sim_empty", 32'(empty), 1);

    // rx_done held high stores one byte
    do_reset();
    rx_data = 8'h77;
    rx_done = 1'b1;
    cyc(10);
    rx_done = 1'b0;
    send_one("hold", 8'h77);
    watch_idle("hold_one_byte", 20);
    check("hold_empty", 32'(empty), 1);

    // reset while a transfer is in flight
    push(8'h88);
    push(8'h99);
    wait_req(n);
    check("abort_pre", 32'(tx_run), 1);
    reset = 1'b1;
    cyc(1);
    check("abort_tx_run", 32'(tx_run), 0);
    check("abort_empty", 32'(empty), 1);
    reset = 1'b0;
    watch_idle("abort_quiet", 30);

`ifdef UART_BUF_LEVEL_EN
    do_reset();
    for (int i = 0; i < 8; i++) push(8'(8'h40 + i));
    cyc(3);
    check("level_8", 32'(level), 8);
    check("half_8", 32'(half), 1);
    send_one("level_pop", 8'h40);
    check("level_7", 32'(level), 7);
    check("half_7", 32'(half), 0);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end

endmodule
